// File: rtl/cpu_datapath_pkg.sv
// Shared codes for the address generators and the ALU.
package cpu_datapath_pkg;

    // Address-low base select (abl_op[3:2])
    localparam logic [1:0] ABL_BASE_HOLD = 2'b00;
    localparam logic [1:0] ABL_BASE_PCL  = 2'b01;
    localparam logic [1:0] ABL_BASE_AHL  = 2'b10;
    localparam logic [1:0] ABL_BASE_DB   = 2'b11;

    // Address-low offset select (abl_op[1:0])
    localparam logic [1:0] ABL_OFS_ZERO  = 2'b00;
    localparam logic [1:0] ABL_OFS_REG   = 2'b01;
    localparam logic [1:0] ABL_OFS_DB    = 2'b10;
    localparam logic [1:0] ABL_OFS_FF    = 2'b11;

    // Address-high base select (abh_op[1:0])
    localparam logic [1:0] ABH_BASE_HOLD = 2'b00;
    localparam logic [1:0] ABH_BASE_PCH  = 2'b01;
    localparam logic [1:0] ABH_BASE_DB   = 2'b10;
    localparam logic [1:0] ABH_BASE_ZERO = 2'b11;

    // ALU function (alu_op[4:2])
    typedef enum logic [2:0] {
        ALU_OR   = 3'b000,
        ALU_AND  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_fn_e;

endpackage

// File: rtl/cpu_datapath_if.sv
// Datapath control/operand bus; master drives operands, slave returns AB and ALU results.
interface cpu_datapath_if;
    logic [3:0]  abl_op;
    logic        abl_ci;
    logic [2:0]  abh_op;
    logic        abh_ff;
    logic [7:0]  PCL;
    logic [7:0]  PCH;
    logic [7:0]  AHL;
    logic [7:0]  DB;
    logic [7:0]  REG;
    logic [7:0]  M;
    logic [4:0]  alu_op;
    logic        alu_ci;
    logic        alu_si;
    logic [15:0] AB;
    logic        abl_co;
    logic [7:0]  alu_out;
    logic        alu_co;
    logic        alu_v;

    modport master (
        output abl_op, abl_ci, abh_op, abh_ff, PCL, PCH, AHL, DB, REG, M,
               alu_op, alu_ci, alu_si,
        input  AB, abl_co, alu_out, alu_co, alu_v
    );

    modport slave (
        input  abl_op, abl_ci, abh_op, abh_ff, PCL, PCH, AHL, DB, REG, M,
               alu_op, alu_ci, alu_si,
        output AB, abl_co, alu_out, alu_co, alu_v
    );
endinterface

// File: rtl/cpu_datapath_abh.sv
// Address-high generator: base + carry, vector-page force, own hold register.
module cpu_datapath_abh
    import cpu_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic [1:0] i_base_sel,
    input  logic       i_carry,
    input  logic       i_ff,
    input  logic [7:0] i_pch,
    input  logic [7:0] i_db,
    output logic [7:0] o_abh
);
    logic [7:0] r_abh;
    logic [7:0] w_base;

    // Base mux, carry add, then the 0xFF force overrides everything
    always_comb begin
        w_base = r_abh;
        case (i_base_sel)
            ABH_BASE_HOLD: w_base = r_abh;
            ABH_BASE_PCH:  w_base = i_pch;
            ABH_BASE_DB:   w_base = i_db;
            ABH_BASE_ZERO: w_base = 8'h00;
            default:       w_base = r_abh;
        endcase
        o_abh = i_ff ? 8'hFF : (w_base + {7'h00, i_carry});
    end

    // Hold register captures the live address high, forced value included
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_abh <= 8'h00;
        else      r_abh <= o_abh;
    end
endmodule

// File: rtl/cpu_datapath_abl.sv
// Address-low generator: base + offset + carry, with its own hold register.
module cpu_datapath_abl
    import cpu_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] i_op,
    input  logic       i_ci,
    input  logic [7:0] i_pcl,
    input  logic [7:0] i_ahl,
    input  logic [7:0] i_db,
    input  logic [7:0] i_reg,
    output logic [7:0] o_abl,
    output logic       o_co
);
    logic [7:0] r_abl;
    logic [7:0] w_base;
    logic [7:0] w_ofs;

    // Base and offset muxes
    always_comb begin
        w_base = r_abl;
        w_ofs  = 8'h00;
        case (i_op[3:2])
            ABL_BASE_HOLD: w_base = r_abl;
            ABL_BASE_PCL:  w_base = i_pcl;
            ABL_BASE_AHL:  w_base = i_ahl;
            ABL_BASE_DB:   w_base = i_db;
            default:       w_base = r_abl;
        endcase
        case (i_op[1:0])
            ABL_OFS_ZERO:  w_ofs = 8'h00;
            ABL_OFS_REG:   w_ofs = i_reg;
            ABL_OFS_DB:    w_ofs = i_db;
            ABL_OFS_FF:    w_ofs = 8'hFF;
            default:       w_ofs = 8'h00;
        endcase
    end

    assign {o_co, o_abl} = {1'b0, w_base} + {1'b0, w_ofs} + {8'h00, i_ci};

    // Hold register captures the live address low every cycle
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_abl <= 8'h00;
        else      r_abl <= o_abl;
    end
endmodule

// File: rtl/cpu_datapath_alu.sv
// Combinational 8-bit ALU: logic ops, add/subtract, shifts, pass-through.
module cpu_datapath_alu
    import cpu_datapath_pkg::*;
(
    input  logic [4:0] i_op,
    input  logic [7:0] i_r,
    input  logic [7:0] i_m,
    input  logic       i_ci,
    input  logic       i_si,
    output logic [7:0] o_out,
    output logic       o_co,
    output logic       o_v
);
    alu_fn_e    w_fn;
    logic [7:0] w_s;
    logic [7:0] w_b;
    logic [8:0] w_sum;
    logic       w_unused_rsvd;

    assign w_fn          = alu_fn_e'(i_op[4:2]);
    assign w_unused_rsvd = i_op[1];

    // Subtract reuses the adder with M inverted; CI supplies the +1
    always_comb begin
        w_s   = i_op[0] ? i_m : i_r;
        w_b   = (w_fn == ALU_SUB) ? ~i_m : i_m;
        w_sum = {1'b0, i_r} + {1'b0, w_b} + {8'h00, i_ci};
        o_out = 8'h00;
        o_co  = 1'b0;
        o_v   = i_m[6];
        case (w_fn)
            ALU_OR:   o_out = i_r | i_m;
            ALU_AND:  o_out = i_r & i_m;
            ALU_XOR:  o_out = i_r ^ i_m;
            ALU_ADD, ALU_SUB: begin
                o_out = w_sum[7:0];
                o_co  = w_sum[8];
                o_v   = (i_r[7] == w_b[7]) && (w_sum[7] != i_r[7]);
            end
            ALU_SHL: begin
                o_out = {w_s[6:0], i_si};
                o_co  = w_s[7];
            end
            ALU_SHR: begin
                o_out = {i_si, w_s[7:1]};
                o_co  = w_s[0];
            end
            ALU_PASS: o_out = i_m;
            default:  o_out = 8'h00;
        endcase
    end
endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath top: address-low/high generators and ALU; forms the ABH carry.
module cpu_datapath
    import cpu_datapath_pkg::*;
(
    input  logic           clk,
    input  logic           RST,
    cpu_datapath_if.slave  bus
);
    logic [7:0] w_abl;
    logic [7:0] w_abh;
    logic       w_abl_co;
    logic       w_abh_carry;

    // abh_op[2] picks the page-crossing carry, otherwise abh_op[1] is a constant carry
    assign w_abh_carry = bus.abh_op[2] ? w_abl_co : bus.abh_op[1];

    cpu_datapath_abl u_abl (
        .clk   (clk),
        .RST   (RST),
        .i_op  (bus.abl_op),
        .i_ci  (bus.abl_ci),
        .i_pcl (bus.PCL),
        .i_ahl (bus.AHL),
        .i_db  (bus.DB),
        .i_reg (bus.REG),
        .o_abl (w_abl),
        .o_co  (w_abl_co)
    );

    cpu_datapath_abh u_abh (
        .clk        (clk),
        .RST        (RST),
        .i_base_sel (bus.abh_op[1:0]),
        .i_carry    (w_abh_carry),
        .i_ff       (bus.abh_ff),
        .i_pch      (bus.PCH),
        .i_db       (bus.DB),
        .o_abh      (w_abh)
    );

    cpu_datapath_alu u_alu (
        .i_op  (bus.alu_op),
        .i_r   (bus.REG),
        .i_m   (bus.M),
        .i_ci  (bus.alu_ci),
        .i_si  (bus.alu_si),
        .o_out (bus.alu_out),
        .o_co  (bus.alu_co),
        .o_v   (bus.alu_v)
    );

    assign bus.AB     = {w_abh, w_abl};
    assign bus.abl_co = w_abl_co;
endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed cases then random operands against an arithmetic model.
module tb_cpu_datapath;
    logic clk;
    logic RST;
    int   checks;
    int   errors;
    int   hold_l;
    int   hold_h;

    cpu_datapath_if bus();

    cpu_datapath dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Model address generation straight from the selection tables
    task automatic model_ab(output int abl, output int co, output int abh);
        int base, ofs, sum, hb, c;
        case (int'(bus.abl_op[3:2]))
            0: base = hold_l;
            1: base = int'(bus.PCL);
            2: base = int'(bus.AHL);
            default: base = int'(bus.DB);
        endcase
        case (int'(bus.abl_op[1:0]))
            0: ofs = 0;
            1: ofs = int'(bus.REG);
            2: ofs = int'(bus.DB);
            default: ofs = 255;
        endcase
        sum = base + ofs + int'(bus.abl_ci);
        abl = sum % 256;
        co  = sum / 256;
        case (int'(bus.abh_op[1:0]))
            0: hb = hold_h;
            1: hb = int'(bus.PCH);
            2: hb = int'(bus.DB);
            default: hb = 0;
        endcase
        c   = bus.abh_op[2] ? co : int'(bus.abh_op[1]);
        abh = bus.abh_ff ? 255 : (hb + c) % 256;
    endtask

    task automatic model_alu(output int res, output int co, output int v);
        int r, m, s, b, t;
        r = int'(bus.REG);
        m = int'(bus.M);
        s = bus.alu_op[0] ? m : r;
        co = 0;
        v  = int'(bus.M[6]);
        res = 0;
        case (int'(bus.alu_op[4:2]))
            0: res = r | m;
            1: res = r & m;
            2: res = r ^ m;
            3, 4: begin
                b   = (bus.alu_op[4:2] == 3'd4) ? 255 - m : m;
                t   = r + b + int'(bus.alu_ci);
                res = t % 256;
                co  = t / 256;
                t   = sx8(r) + sx8(b) + int'(bus.alu_ci);
                v   = (t > 127 || t < -128) ? 1 : 0;
            end
            5: begin res = (s * 2 + int'(bus.alu_si)) % 256; co = s / 128; end
            6: begin res = s / 2 + 128 * int'(bus.alu_si); co = s % 2; end
            default: res = m;
        endcase
    endtask

    // Check all outputs for the current inputs, then clock and advance the model holds
    task automatic cycle(input string tag);
        int eabl, eco, eabh, eres, eaco, ev;
        logic [15:0] exp_ab;
        model_ab(eabl, eco, eabh);
        model_alu(eres, eaco, ev);
        exp_ab = 16'(eabh * 256 + eabl);
        #1;
        checks++;
        assert (bus.AB === exp_ab) else begin
            errors++; $error("FAIL %s AB got %h want %h", tag, bus.AB, exp_ab);
        end
        checks++;
        assert (bus.abl_co === 1'(eco)) else begin
            errors++; $error("FAIL %s abl_co got %b want %0d", tag, bus.abl_co, eco);
        end
        checks++;
        assert (bus.alu_out === 8'(eres)) else begin
            errors++; $error("FAIL %s alu_out got %h want %h", tag, bus.alu_out, 8'(eres));
        end
        checks++;
        assert (bus.alu_co === 1'(eaco)) else begin
            errors++; $error("FAIL %s alu_co got %b want %0d", tag, bus.alu_co, eaco);
        end
        checks++;
        assert (bus.alu_v === 1'(ev)) else begin
            errors++; $error("FAIL %s alu_v got %b want %0d", tag, bus.alu_v, ev);
        end
        @(posedge clk);
        if (RST) begin
            hold_l = eabl;
            hold_h = eabh;
        end else begin
            hold_l = 0;
            hold_h = 0;
        end
        #2;
    endtask

    // Fixed literal checks for the directed vectors, independent of the model
    task automatic expect_ab(input string tag, input logic [15:0] want);
        #1;
        checks++;
        assert (bus.AB === want) else begin
            errors++; $error("FAIL %s AB got %h want %h", tag, bus.AB, want);
        end
    endtask

    task automatic expect_alu(input string tag, input logic [7:0] o, input logic c, input logic v);
        #1;
        checks++;
        assert ({bus.alu_out, bus.alu_co, bus.alu_v} === {o, c, v}) else begin
            errors++;
            $error("FAIL %s alu got %h/%b/%b want %h/%b/%b", tag,
                   bus.alu_out, bus.alu_co, bus.alu_v, o, c, v);
        end
    endtask

    initial begin
        checks = 0; errors = 0; hold_l = 0; hold_h = 0;
        RST = 1'b0;
        bus.abl_op = 4'h0; bus.abl_ci = 1'b0; bus.abh_op = 3'h0; bus.abh_ff = 1'b0;
        bus.PCL = 8'h00; bus.PCH = 8'h00; bus.AHL = 8'h00; bus.DB = 8'h00;
        bus.REG = 8'h00; bus.M = 8'h00; bus.alu_op = 5'h00; bus.alu_ci = 1'b0; bus.alu_si = 1'b0;
        #2;
        cycle("reset0");
        cycle("reset1");
        RST = 1'b1;

        // Held address stays at zero
        for (int i = 0; i < 3; i++) begin
            expect_ab("hold0", 16'h0000);
            cycle("hold0_m");
        end

        // PC increment crossing a page
        bus.PCL = 8'hFF; bus.PCH = 8'h12; bus.abl_op = 4'b0100; bus.abl_ci = 1'b1; bus.abh_op = 3'b101;
        expect_ab("pc_inc", 16'h1300);
        cycle("pc_inc_m");

        // Zero page with carry, then stack page
        bus.abl_ci = 1'b0; bus.AHL = 8'h80; bus.REG = 8'h90; bus.abl_op = 4'b1001; bus.abh_op = 3'b111;
        expect_ab("zp_carry", 16'h0110);
        cycle("zp_carry_m");
        bus.abh_op = 3'b011; bus.abl_op = 4'b1000; bus.AHL = 8'hFD;
        expect_ab("stack", 16'h01FD);
        cycle("stack_m");

        // Vector page force, then held
        bus.abh_ff = 1'b1; bus.abh_op = 3'b010; bus.DB = 8'h34;
        cycle("vec_ff");
        bus.abh_ff = 1'b0; bus.abh_op = 3'b000;
        cycle("vec_hold");

        // ALU directed vectors
        bus.REG = 8'h7F; bus.M = 8'h01; bus.alu_ci = 1'b0; bus.alu_op = 5'b01100;
        expect_alu("add_ovf", 8'h80, 1'b0, 1'b1);
        cycle("add_ovf_m");
        bus.REG = 8'h10; bus.M = 8'h20; bus.alu_ci = 1'b1; bus.alu_op = 5'b10000;
        expect_alu("sub_lt", 8'hF0, 1'b0, 1'b0);
        cycle("sub_lt_m");
        bus.REG = 8'h5A; bus.M = 8'h5A;
        expect_alu("sub_eq", 8'h00, 1'b1, 1'b0);
        cycle("sub_eq_m");
        bus.M = 8'h81; bus.alu_si = 1'b1; bus.alu_op = 5'b10101;
        expect_alu("shl_m", 8'h03, 1'b1, 1'b0);
        cycle("shl_m_m");
        bus.REG = 8'h01; bus.alu_si = 1'b0; bus.alu_op = 5'b11000;
        cycle("shr_r");

        // Asynchronous reset between edges clears holds at once
        bus.abl_op = 4'b0100; bus.abh_op = 3'b001; bus.PCL = 8'hA5; bus.PCH = 8'h5A;
        cycle("preload");
        bus.abl_op = 4'b0000; bus.abh_op = 3'b000;
        RST = 1'b0;
        hold_l = 0; hold_h = 0;
        expect_ab("async_rst", 16'h0000);
        cycle("async_rst_m");
        RST = 1'b1;
        bus.abl_op = 4'b0011; bus.abh_op = 3'b010; bus.DB = 8'h42;
        cycle("first_load");
        bus.abl_op = 4'b0000; bus.abh_op = 3'b000;
        cycle("after_load");

        // Random operands and controls
        for (int i = 0; i < 200; i++) begin
            bus.abl_op = 4'($urandom); bus.abl_ci = 1'($urandom);
            bus.abh_op = 3'($urandom); bus.abh_ff = ($urandom_range(0, 7) == 0);
            bus.PCL = 8'($urandom); bus.PCH = 8'($urandom); bus.AHL = 8'($urandom);
            bus.DB = 8'($urandom); bus.REG = 8'($urandom); bus.M = 8'($urandom);
            bus.alu_op = 5'($urandom); bus.alu_ci = 1'($urandom); bus.alu_si = 1'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 Parameters: none; data width fixed at 8, address width fixed at 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 abl_op  input  4  address-low operation; [3:2] base select, [1:0] offset select.
REQ-005 abl_ci  input  1  address-low carry in.
REQ-006 abh_op  input  3  address-high operation; [1:0] base select, [2] carry source.
REQ-007 abh_ff  input  1  force address-high to 0xFF (vector page).
REQ-008 PCL, PCH  input  8 each  program counter bytes.
REQ-009 AHL  input  8  address-hold-low byte.
REQ-010 DB  input  8  data bus read value.
REQ-011 REG  input  8  register-file read value (index/ALU operand R).
REQ-012 M  input  8  registered memory operand.
REQ-013 alu_op  input  5  ALU function; [4:2] function, [0] shift-source select.
REQ-014 alu_ci, alu_si  input  1 each  ALU carry-in, shift-in.
REQ-015 AB  output  16  address bus {ABH, ABL}, combinational.
REQ-016 abl_co  output  1  carry out of address-low adder.
REQ-017 alu_out  output  8;  alu_co, alu_v  output  1 each  ALU result, carry, overflow.

Function
REQ-018 Address-low base, by abl_op[3:2]: 00 held ABL register; 01 PCL; 10 AHL; 11 DB.
REQ-019 Address-low offset, by abl_op[1:0]: 00 0x00; 01 REG; 10 DB; 11 0xFF.
REQ-020 ABL = base + offset + abl_ci (8-bit wrap); abl_co = bit 8 of that 9-bit sum.
REQ-021 Held ABL register loads the current ABL every clock.
REQ-022 Address-high carry = abh_op[2] ? abl_co : abh_op[1].
REQ-023 Address-high base, by abh_op[1:0]: 00 held ABH register; 01 PCH; 10 DB; 11 0x00.
REQ-024 ABH = base + carry (8-bit wrap, no carry out); when abh_ff=1, ABH = 0xFF regardless of abh_op.
REQ-025 Held ABH register loads the current ABH every clock, including 0xFF when forced.
REQ-026 abh_op 011 yields stack page 0x01; 111 yields 0x00 + abl_co (zero page with carry).
REQ-027 ALU is purely combinational; zero latency from any input to alu_out, alu_co, alu_v.
REQ-028 ALU function, by alu_op[4:2]: 000 R|M; 001 R&M; 010 R^M; 011 R+M+CI; 100 R+~M+CI; 101 shift-left {S[6:0],SI}; 110 shift-right {SI,S[7:1]}; 111 pass M.
REQ-029 Shift source S = alu_op[0] ? M : R; alu_op[1] is reserved and ignored.
REQ-030 alu_co: bit 8 of the sum for 011/100; S[7] for shift-left; S[0] for shift-right; 0 otherwise.
REQ-031 alu_v: signed overflow of the add (operands R and M, or R and ~M for 100); M[6] for all other functions.
REQ-032 Subtract with CI=1 and R==M gives alu_out 0x00, alu_co 1; R<M unsigned gives alu_co 0.

Reset
REQ-033 RST low asynchronously clears held ABL and held ABH registers to 0x00.
REQ-034 During reset, AB and ALU outputs follow their combinational equations using cleared held values.
REQ-035 The first rising clk edge after RST deasserts performs a normal hold-register load.

Structure
REQ-036 Shared package holds abl base/offset codes, abh base codes and ALU function codes as named constants.
REQ-037 Three sub-modules: abl, abh (each owning its hold register), alu (combinational); cpu_datapath instantiates them and forms the abh carry.

Verification
REQ-038 Reset, then abl_op=0000, abh_op=000, ci=0 -> AB=0x0000 held across 3 clocks.
REQ-039 PCL=0xFF, PCH=0x12, abl_op=0100, abl_ci=1, abh_op=101 -> AB=0x1300, abl_co=1.
REQ-040 AHL=0x80, REG=0x90, abl_op=1001, abh_op=111 -> AB=0x0110; abh_op=011, abl_op=1000, AHL=0xFD -> AB=0x01FD.
REQ-041 abh_ff=1, abh_op=010, DB=0x34 -> ABH=0xFF; next clock abh_op=000, abh_ff=0 -> ABH=0xFF held.
REQ-042 ALU add R=0x7F, M=0x01, CI=0 -> out 0x80, co 0, v 1; sub R=0x10, M=0x20, CI=1 -> out 0xF0, co 0, v 0.
REQ-043 ALU shift-left alu_op[0]=1, M=0x81, SI=1 -> out 0x03, co 1; shift-right R=0x01, SI=0 -> out 0x00, co 1.
